riscv_dmem_ctrl: RTL and testbench
==================================

# riscv_dmem_ctrl

Parametrised data-memory controller for the next-generation single-cycle RISC-V SoC, replacing the fixed zero-latency word memory on the core's data port. Adds byte/halfword/word loads and stores with sign/zero extension, a configurable number of wait states with a stall handshake to the core, and error signalling for misaligned, out-of-range or illegal accesses. Sits between the core's data port and the SoC memory space; instruction memory is unchanged.

## Interface
- `DEPTH`, 256: memory size in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 1: extra wait states per access, 0..15.
- `INIT_FILE`, "": hex image loaded at elaboration when non-empty.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `req_valid`  in  1  core presents a load/store this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  3  RISC-V funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0 SB, 1 SH, 2 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `stall`  out  1  core must hold PC and request stable while high.
- `rsp_valid`  out  1  one-cycle pulse: access complete.
- `rdata`  out  32  extended load data, valid with `rsp_valid`.
- `err`  out  1  access rejected, valid with `rsp_valid`.

## Operation
- FSM states IDLE, BUSY, DONE; encoding in package.
- IDLE: on a rising edge with `req_valid`=1, latch we/size/addr/wdata, load `cnt`←WAIT_CYCLES, check legality; legal → BUSY, illegal → DONE with err.
- BUSY: `cnt`≠0 → decrement; `cnt`=0 → perform access (commit store or register load result), → DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, → IDLE.
- `stall` = (IDLE & `req_valid`) | BUSY; low in DONE so the core advances on the edge ending DONE.
- Inputs are ignored after latching; changes during BUSY have no effect.
- Illegal: funct3 ∉ {0,1,2,4,5} for loads, ∉ {0,1,2} for stores; halfword with addr[0]=1; word with addr[1:0]≠0; word index addr[31:2] ≥ DEPTH. Illegal access: no memory write, `rdata`=0, `err`=1.
- Loads: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- Stores: wdata[7:0] replicated to lane addr[1:0] (SB), wdata[15:0] to lane addr[1] (SH); 4-bit byte-enable, unselected bytes unchanged.
- Memory array word-addressed by addr[log2(DEPTH)+1:2]; contents not cleared by reset.

## Timing
- Reset values: state IDLE, `cnt`=0, `stall`=0 unless `req_valid` (combinational), `rsp_valid`=0, `rdata`=0, `err`=0.
- Legal access: `stall` high WAIT_CYCLES+2 cycles (1 IDLE + WAIT_CYCLES+1 BUSY); `rsp_valid` in the following cycle; store visible to a load accepted after DONE.
- WAIT_CYCLES=0: stall 2 cycles, response in cycle 2 counted from first presentation.
- Illegal access: stall 1 cycle, DONE next.
- Back-to-back: new request may be presented in the cycle after DONE and is accepted at the end of that IDLE cycle; no request accepted in DONE.
- Reset asserted in BUSY before the `cnt`=0 edge: store not committed, no response; reset at any point returns IDLE within the same cycle.

## Structure
- `riscv_pkg`: funct3 constants (LB..LHU, SB..SW), FSM state typedef, `WAIT_W` counter width.
- Sub-module `dmem_load_ext`: combinational lane select and sign/zero extension (word, addr[1:0], size → rdata). Byte-enable generation stays in the top.

## Test plan
- Reset, DEPTH=256, WAIT_CYCLES=1: SW 0xDEADBEEF @0x10 → stall 3 cycles, rsp_valid next, err=0; LW @0x10 → rdata 0xDEADBEEF.
- SB 0x80 @0x13 then LB @0x13 → 0xFFFFFF80, LBU → 0x00000080, LW @0x10 → 0x80ADBEEF.
- SH 0x8001 @0x12, LH @0x12 → 0xFFFF8001, LHU → 0x00008001; LH @0x11 → err=1, rdata 0, stall 1 cycle.
- SW @0x400 (word index 256 ≥ DEPTH) → err=1, no write; funct3=3 load → err=1.
- WAIT_CYCLES=0 and 15: stall lengths 2 and 17 cycles; requests toggled during BUSY do not alter result.
- Reset low mid-BUSY of SW 0x12345678 @0x20 → rsp_valid never pulses, subsequent LW @0x20 returns prior contents.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory controller: funct3 encodings,
// controller state type and wait-counter width.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane select and sign/zero extension of a memory word.
module dmem_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word_i >> {addr_lo_i, 3'b000});
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   rdata_o = word_i;
            F3_LBU:  rdata_o = {24'd0, byte_sel};
            F3_LHU:  rdata_o = {16'd0, half_sel};
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller for the core's data port: sized loads/stores,
// configurable wait states with stall handshake, and access error reporting.
module riscv_dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    state_e              state_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                we_q;
    logic [2:0]          size_q;
    logic [AW+1:0]       addr_q;
    logic [31:0]         wdata_q;
    logic                rsp_valid_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    logic [31:0]         mem [DEPTH];

    // Legality is judged on the live request, at the accepting edge.
    logic size_ok, align_ok, range_ok, legal;
    always_comb begin
        if (req_we)
            size_ok = req_size inside {F3_SB, F3_SH, F3_SW};
        else
            size_ok = req_size inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        case (req_size[1:0])
            2'd1:    align_ok = ~req_addr[0];
            2'd2:    align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        range_ok = (req_addr[31:AW+2] == '0);
        legal    = size_ok & align_ok & range_ok;
    end

    logic [AW-1:0] widx;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          commit;

    assign widx = addr_q[AW+1:2];

    dmem_load_ext u_ext (
        .word_i    (mem[widx]),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .rdata_o   (ld_data)
    );

    always_comb begin
        case (size_q[1:0])
            2'd0: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    // Reset drops state_q to IDLE asynchronously, so an interrupted store never commits.
    assign commit = (state_q == ST_BUSY) && (cnt_q == '0) && we_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        addr_q      <= req_addr[AW+1:0];
                        wdata_q     <= req_wdata;
                        cnt_q       <= WAIT_W'(WAIT_CYCLES);
                        rdata_q     <= 32'd0;
                        err_q       <= ~legal;
                        rsp_valid_q <= ~legal;
                        state_q     <= legal ? ST_BUSY : ST_DONE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (!we_q) rdata_q <= ld_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall     = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_BUSY);
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: three instances (0, 1 and 15 wait states) share one
// request bus; a byte-array model predicts load data, errors and timing.
module tb_riscv_dmem_ctrl;

    localparam int DEPTH = 256;
    localparam int NDUT  = 3;
    localparam int WAITS [NDUT] = '{0, 1, 15};
    localparam int WIN   = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [NDUT-1:0] stall_w, rsp_w, err_w;
    logic [31:0] rdata_w [NDUT];

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem_m [DEPTH*4];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            riscv_dmem_ctrl #(
                .DEPTH       (DEPTH),
                .WAIT_CYCLES (WAITS[g]),
                .INIT_FILE   ("")
            ) u_dut (
                .clk       (clk),
                .reset     (rst_n),
                .req_valid (req_valid),
                .req_we    (req_we),
                .req_size  (req_size),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .stall     (stall_w[g]),
                .rsp_valid (rsp_w[g]),
                .rdata     (rdata_w[g]),
                .err       (err_w[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input logic we, input logic [2:0] sz, input logic [31:0] a);
        bit ok;
        if (we) ok = (sz <= 3'd2);
        else    ok = (sz <= 3'd2) || sz == 3'd4 || sz == 3'd5;
        if (ok && (a % nbytes(sz)) != 0) ok = 0;
        if (ok && (a / 4) >= DEPTH)      ok = 0;
        return ok;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        longint v = 0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v += longint'(mem_m[a+i]) << (8*i);
        if (sz < 3'd2 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    // One access, observed over a fixed window on all instances.
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit toggle,
                          output logic [31:0] rd1, output logic err1);
        bit          lg;
        logic [31:0] exp_rd;
        int          stc [NDUT];
        int          rc  [NDUT];
        int          rcy [NDUT];
        logic [31:0] rd  [NDUT];
        logic        e   [NDUT];
        lg     = model_legal(we, sz, a);
        exp_rd = (!we && lg) ? model_load(sz, a) : 32'd0;
        if (we && lg)
            for (int i = 0; i < nbytes(sz); i++) mem_m[a+i] = 8'(wd >> (8*i));
        for (int d = 0; d < NDUT; d++) begin
            stc[d] = 0; rc[d] = 0; rcy[d] = -1; rd[d] = 'x; e[d] = 1'bx;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        for (int cyc = 0; cyc < WIN; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (toggle) begin
                    req_we = 1'($urandom); req_size = 3'($urandom);
                    req_addr = $urandom; req_wdata = $urandom;
                end
            end
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (stall_w[d]) stc[d]++;
                if (rsp_w[d]) begin
                    rc[d]++; rcy[d] = cyc; rd[d] = rdata_w[d]; e[d] = err_w[d];
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("stall_len w%0d a%0h", WAITS[d], a), stc[d], lg ? WAITS[d] + 2 : 1);
            chk($sformatf("rsp_count w%0d a%0h", WAITS[d], a), rc[d], 1);
            chk($sformatf("rsp_cycle w%0d a%0h", WAITS[d], a), rcy[d], lg ? WAITS[d] + 2 : 1);
            chk($sformatf("err w%0d a%0h", WAITS[d], a), {31'd0, e[d]}, {31'd0, ~lg});
            if (!we || !lg)
                chk($sformatf("rdata w%0d a%0h sz%0d", WAITS[d], a, sz), rd[d], exp_rd);
        end
        rd1  = rd[1];
        err1 = e[1];
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          cnt;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'd0;

        #2;
        chk("reset stall", {29'd0, stall_w}, 32'd0);
        chk("reset rsp_valid", {29'd0, rsp_w}, 32'd0);
        chk("reset err", {29'd0, err_w}, 32'd0);
        for (int d = 0; d < NDUT; d++) chk("reset rdata", rdata_w[d], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < 16; w++) access(1'b1, 3'd2, 32'(w*4), $urandom, 1'b0, rd, e);

        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd, e);
        access(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, rd, e);
        chk("LW 0x10", rd, 32'hDEADBEEF);
        access(1'b1, 3'd0, 32'h13, 32'h80, 1'b1, rd, e);
        access(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, rd, e);
        chk("LB 0x13", rd, 32'hFFFFFF80);
        access(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, rd, e);
        chk("LBU 0x13", rd, 32'h00000080);
        access(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, e);
        chk("LW after SB", rd, 32'h80ADBEEF);
        access(1'b1, 3'd1, 32'h12, 32'h8001, 1'b0, rd, e);
        access(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, rd, e);
        chk("LH 0x12", rd, 32'hFFFF8001);
        access(1'b0, 3'd5, 32'h12, 32'h0, 1'b0, rd, e);
        chk("LHU 0x12", rd, 32'h00008001);
        access(1'b0, 3'd1, 32'h11, 32'h0, 1'b0, rd, e);
        chk("LH misaligned err", {31'd0, e}, 32'd1);
        access(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 1'b0, rd, e);
        chk("SW out of range err", {31'd0, e}, 32'd1);
        access(1'b0, 3'd3, 32'h10, 32'h0, 1'b0, rd, e);
        chk("funct3=3 load err", {31'd0, e}, 32'd1);
        access(1'b1, 3'd4, 32'h10, 32'h0, 1'b0, rd, e);
        access(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, e);
        chk("no write from illegal store", rd, 32'h8001BEEF);

        // Reset while every instance is in BUSY: store must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("stall in reset", {29'd0, stall_w}, 32'd0);
        chk("rsp in reset", {29'd0, rsp_w}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            #1;
            if (rsp_w != '0) cnt++;
        end
        chk("no rsp after reset", cnt, 0);
        access(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, rd, e);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'h400 + $urandom_range(0, 63) : $urandom_range(0, 63);
            access(1'($urandom), 3'($urandom), a, $urandom, 1'b1, rd, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
